// File: rtl/pic_port.sv
// pic_port: simplified 8-input programmable interrupt controller on the core's
// I/O port bus. It latches rising edges on irq_lines and arbitrates them by
// fixed priority (line 0 highest). It issues one vector at a time through the
// core's toggle handshake: a request is pending while intr != intl.
//
// Ports:
//   clock, reset  - system clock; synchronous active-high reset
//   irq_lines[7:0]- device requests, rising-edge triggered
//   port[15:0]    - port address; BASE..BASE+3 are decoded
//   port_clk      - access strobe; a 0->1 transition marks one access
//   port_o[7:0]   - write data from the core
//   port_w        - 1 = write, 0 = read
//   port_i[7:0]   - registered read data (8'hFF when the address misses)
//   irq[7:0]      - vector number (VB + line)
//   intr          - request toggle to the core
//   intl          - acknowledge toggle from the core
//
// Register map (offset = port[1:0]):
//   0 R: IRR   W: 8'h20 non-specific EOI, 8'b0110_0nnn specific EOI
//   1 R/W: IMR
//   2 R: ISR (writes ignored)
//   3 R/W: VB (vector base)
module pic_port #(
  parameter logic [15:0] BASE     = 16'h0020,
  parameter logic [7:0]  VEC_BASE = 8'h08
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_lines,
  input  logic [15:0] port,
  input  logic        port_clk,
  input  logic [7:0]  port_o,
  input  logic        port_w,
  output logic [7:0]  port_i,
  output logic [7:0]  irq,
  output logic        intr,
  input  logic        intl
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Index of the lowest set bit, or 8 when the vector is empty. Returning 8
  // for "nothing in service" lets the priority compare be a plain p < s.
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[3:0];
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  irr_q, irr_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  imr_q, imr_d;
  logic [7:0]  vb_q, vb_d;
  logic [7:0]  lines_prev_q, lines_prev_d;
  logic        pclk_prev_q, pclk_prev_d;
  logic        intr_q, intr_d;
  logic [7:0]  irq_q, irq_d;
  logic [7:0]  port_i_q, port_i_d;

  logic [7:0]  rise;
  logic        stb, hit, wr;
  logic [7:0]  req;
  logic [3:0]  p_idx, s_idx;
  logic        cand, issue;
  logic [7:0]  issue_mask, eoi_mask;

  always_comb begin
    rise  = irq_lines & ~lines_prev_q;
    stb   = port_clk & ~pclk_prev_q;
    hit   = (port[15:2] == BASE[15:2]);
    wr    = stb & hit & port_w;

    req   = irr_q & ~imr_q;
    p_idx = lowest_set(req);
    s_idx = lowest_set(isr_q);
    // Only strictly higher priority than everything in service may nest.
    cand  = (req != 8'h00) && (p_idx < s_idx);
    issue = (state_q == ST_IDLE) && cand;

    issue_mask = issue ? (8'd1 << p_idx[2:0]) : 8'h00;

    // Non-specific EOI looks at the pre-EOI ISR, same as arbitration.
    eoi_mask = 8'h00;
    if (wr && (port[1:0] == 2'd0)) begin
      if (port_o == 8'h20) begin
        if (s_idx < 4'd8) eoi_mask = 8'd1 << s_idx[2:0];
      end else if (port_o[7:3] == 5'b01100) begin
        eoi_mask = 8'd1 << port_o[2:0];
      end
    end

    // A fresh edge on the line being issued survives the clear.
    irr_d = (irr_q & ~issue_mask) | rise;
    isr_d = (isr_q & ~eoi_mask) | issue_mask;
    imr_d = (wr && (port[1:0] == 2'd1)) ? port_o : imr_q;
    vb_d  = (wr && (port[1:0] == 2'd3)) ? port_o : vb_q;

    lines_prev_d = irq_lines;
    pclk_prev_d  = port_clk;

    state_d = state_q;
    intr_d  = intr_q;
    irq_d   = irq_q;
    case (state_q)
      ST_IDLE: begin
        if (cand) begin
          irq_d   = vb_q + {5'd0, p_idx[2:0]};
          intr_d  = ~intr_q;
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (intl == intr_q) state_d = ST_IDLE;
      end
    endcase

    port_i_d = 8'hFF;
    if (hit) begin
      case (port[1:0])
        2'd0:    port_i_d = irr_q;
        2'd1:    port_i_d = imr_q;
        2'd2:    port_i_d = isr_q;
        default: port_i_d = vb_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      irr_q        <= 8'h00;
      isr_q        <= 8'h00;
      imr_q        <= 8'hFF;
      vb_q         <= VEC_BASE;
      lines_prev_q <= 8'h00;
      pclk_prev_q  <= 1'b0;
      intr_q       <= 1'b0;
      irq_q        <= 8'h00;
      port_i_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      imr_q        <= imr_d;
      vb_q         <= vb_d;
      lines_prev_q <= lines_prev_d;
      pclk_prev_q  <= pclk_prev_d;
      intr_q       <= intr_d;
      irq_q        <= irq_d;
      port_i_q     <= port_i_d;
    end
  end

  assign port_i = port_i_q;
  assign irq    = irq_q;
  assign intr   = intr_q;

endmodule

// File: tb/tb_pic_port.sv
module tb_pic_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_lines;
  logic [15:0] port;
  logic        port_clk;
  logic [7:0]  port_o;
  logic        port_w;
  logic [7:0]  port_i;
  logic [7:0]  irq;
  logic        intr;
  logic        intl;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[16];

  pic_port #(.BASE(16'h0020), .VEC_BASE(8'h08)) dut (
    .clock(clock), .reset(reset), .irq_lines(irq_lines), .port(port),
    .port_clk(port_clk), .port_o(port_o), .port_w(port_w), .port_i(port_i),
    .irq(irq), .intr(intr), .intl(intl)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    port = a; port_o = d; port_w = 1'b1; port_clk = 1'b1;
    cyc();
    port_clk = 1'b0; port_w = 1'b0;
    cyc();
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    port = a; port_w = 1'b0;
    cyc();
    chk(name, port_i, exp);
  endtask

  task automatic pulse(input int n);
    irq_lines[n] = 1'b1;
    cyc();
    irq_lines[n] = 1'b0;
  endtask

  // Waits (bounded) for a pending request, then checks the vector against
  // the oldest scoreboard entry. Does not acknowledge.
  task automatic wait_issue(input string name);
    int i;
    logic [7:0] e;
    for (i = 0; i < 20; i++) begin
      if (intr != intl) break;
      cyc();
    end
    if (intr == intl) begin
      total++; bad++;
      $display("FAIL %s: no issue within 20 cycles (intr=%0b intl=%0b)", name, intr, intl);
    end else if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: unexpected vector %02h, scoreboard empty", name, irq);
    end else begin
      e = sb.pop_front();
      chk(name, irq, e);
    end
  endtask

  task automatic ack();
    intl = intr;
    cyc();
  endtask

  task automatic no_issue(input string name, input int n);
    logic ok;
    ok = 1'b1;
    repeat (n) begin
      cyc();
      if (intr != intl) ok = 1'b0;
    end
    chk(name, {7'd0, ok}, 8'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 16'h0021, 8'h00, 8'hFF};
    tbl[1]  = '{1'b0, 16'h0020, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 16'h0022, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 16'h0023, 8'h00, 8'h08};
    tbl[4]  = '{1'b0, 16'h0024, 8'h00, 8'hFF};
    tbl[5]  = '{1'b0, 16'h001F, 8'h00, 8'hFF};
    tbl[6]  = '{1'b1, 16'h0023, 8'h40, 8'h00};
    tbl[7]  = '{1'b0, 16'h0023, 8'h00, 8'h40};
    tbl[8]  = '{1'b1, 16'h0022, 8'h55, 8'h00};
    tbl[9]  = '{1'b0, 16'h0022, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 16'h0021, 8'hA5, 8'h00};
    tbl[11] = '{1'b0, 16'h0021, 8'h00, 8'hA5};
    tbl[12] = '{1'b1, 16'h0025, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 16'h0021, 8'h00, 8'hA5};
    tbl[14] = '{1'b1, 16'h0020, 8'h13, 8'h00};
    tbl[15] = '{1'b0, 16'h0020, 8'h00, 8'h00};

    reset = 1'b1; irq_lines = 8'h00; port = 16'h0021; port_clk = 1'b0;
    port_o = 8'h00; port_w = 1'b0; intl = 1'b0;
    cyc(); cyc();
    chk("rst_port_i", port_i, 8'h00);
    chk("rst_irq", irq, 8'h00);
    chk("rst_intr", {7'd0, intr}, 8'h00);
    reset = 1'b0;

    // Register access table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else rd($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end
    chk("tbl_intr", {7'd0, intr}, 8'h00);

    // Single request on line 0
    wr(16'h0021, 8'hFE);
    wr(16'h0023, 8'h08);
    sb.push_back(8'h08);
    pulse(0);
    wait_issue("line0_vec");
    chk("line0_intr", {7'd0, intr}, 8'h01);
    rd("line0_isr", 16'h0022, 8'h01);
    rd("line0_irr", 16'h0020, 8'h00);
    chk("line0_hold", {7'd0, intr}, 8'h01);
    ack();
    wr(16'h0020, 8'h20);
    rd("line0_eoi", 16'h0022, 8'h00);

    // Simultaneous lines 3 and 5
    wr(16'h0021, 8'h00);
    sb.push_back(8'h0B);
    sb.push_back(8'h0D);
    irq_lines = 8'b0010_1000;
    cyc();
    irq_lines = 8'h00;
    wait_issue("pri_first");
    ack();
    no_issue("pri_blocked", 4);
    wr(16'h0020, 8'h20);
    wait_issue("pri_second");
    ack();
    wr(16'h0020, 8'h20);
    rd("pri_isr", 16'h0022, 8'h00);

    // Nesting and specific EOI
    sb.push_back(8'h0B);
    pulse(3);
    wait_issue("nest_l3");
    ack();
    sb.push_back(8'h09);
    pulse(1);
    wait_issue("nest_l1");
    ack();
    rd("nest_isr", 16'h0022, 8'h0A);
    pulse(6);
    no_issue("nest_l6_blocked", 4);
    wr(16'h0020, 8'h63);
    no_issue("nest_after_spec", 3);
    rd("nest_spec_isr", 16'h0022, 8'h02);
    rd("nest_irr", 16'h0020, 8'h40);
    sb.push_back(8'h0E);
    wr(16'h0020, 8'h20);
    wait_issue("nest_l6");
    ack();
    wr(16'h0020, 8'h20);
    rd("nest_done_isr", 16'h0022, 8'h00);

    // Held line while masked
    wr(16'h0021, 8'h04);
    irq_lines[2] = 1'b1;
    no_issue("hold_masked", 10);
    rd("hold_irr", 16'h0020, 8'h04);
    sb.push_back(8'h0A);
    wr(16'h0021, 8'h00);
    wait_issue("hold_unmask");
    ack();
    rd("hold_isr", 16'h0022, 8'h04);
    wr(16'h0020, 8'h62);
    no_issue("hold_no_reissue", 6);
    rd("hold_irr_clear", 16'h0020, 8'h00);
    irq_lines[2] = 1'b0;

    // Vector wrap-around
    wr(16'h0023, 8'hFC);
    sb.push_back(8'h03);
    pulse(7);
    wait_issue("vb_wrap");
    ack();
    wr(16'h0020, 8'h20);
    wr(16'h0023, 8'h08);

    // Reset while waiting for acknowledge
    sb.push_back(8'h0C);
    pulse(4);
    wait_issue("rst_wait_issue");
    reset = 1'b1; intl = 1'b0;
    cyc();
    reset = 1'b0;
    chk("rst_wait_intr", {7'd0, intr}, 8'h00);
    chk("rst_wait_irq", irq, 8'h00);
    rd("rst_wait_isr", 16'h0022, 8'h00);
    rd("rst_wait_imr", 16'h0021, 8'hFF);
    pulse(0);
    no_issue("rst_masked", 5);
    sb.push_back(8'h08);
    wr(16'h0021, 8'hFE);
    wait_issue("rst_unmask");
    ack();
    wr(16'h0020, 8'h20);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
